keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates one active-low row, debounces the first low column found,
// and reports one key_valid pulse per accepted press while key_held tracks the key.
module keypad_scan_ctrl #(
  parameter logic [15:0] ROW_DWELL  = 16'd250,
  parameter logic [7:0]  DEB_CYCLES = 8'd125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  col_meta_q, col_s_q;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  logic [15:0] dwell_q, dwell_d;
  logic [7:0]  deb_q, deb_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;

  logic        dwell_last;
  logic        deb_last;
  logic        col_low;
  logic [1:0]  low_idx;

  assign dwell_last = (dwell_q == ROW_DWELL - 16'd1);
  assign deb_last   = (deb_q == DEB_CYCLES - 8'd1);
  assign col_low    = ~col_s_q[col_q];

  // Lowest-indexed low column wins when several keys share the driven row.
  always_comb begin
    low_idx = 2'd0;
    if (!col_s_q[0])      low_idx = 2'd0;
    else if (!col_s_q[1]) low_idx = 2'd1;
    else if (!col_s_q[2]) low_idx = 2'd2;
    else if (!col_s_q[3]) low_idx = 2'd3;
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      SCAN: begin
        // Columns are only trusted on the final dwell cycle, after the row has settled.
        if (!dwell_last) begin
          dwell_d = dwell_q + 16'd1;
        end else if (col_s_q == 4'hF) begin
          row_d   = row_q + 2'd1;
          dwell_d = 16'd0;
        end else begin
          col_d   = low_idx;
          deb_d   = 8'd0;
          state_d = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (!col_low) begin
          dwell_d = 16'd0;
          state_d = SCAN;
        end else if (deb_last) begin
          key_valid_d = 1'b1;
          key_code_d  = {row_q, col_q};
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else begin
          deb_d = deb_q + 8'd1;
        end
      end
      HELD: begin
        if (!col_low) begin
          deb_d   = 8'd0;
          state_d = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (col_low) begin
          state_d = HELD;
        end else if (deb_last) begin
          row_d      = row_q + 2'd1;
          dwell_d    = 16'd0;
          key_held_d = 1'b0;
          state_d    = SCAN;
        end else begin
          deb_d = deb_q + 8'd1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      col_meta_q  <= 4'hF;
      col_s_q     <= 4'hF;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      dwell_q     <= 16'd0;
      deb_q       <= 8'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_meta_q  <= col_n;
      col_s_q     <= col_meta_q;
      row_q       <= row_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row_n     = ~(4'b0001 << row_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl with ROW_DWELL=4, DEB_CYCLES=3: a cycle model checked every
// cycle plus directed scenarios with hand-derived timing.
module tb_keypad_scan_ctrl;
  localparam int RD = 4;
  localparam int DC = 3;
  localparam int M_SCAN = 0, M_PRESS = 1, M_HELD = 2, M_REL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n = 4'hF;
  logic [3:0] row_n, key_code;
  logic       key_valid, key_held;

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;
  bit cmp_on = 1'b0;

  // Keypad matrix: key_mask lists the pressed columns on row key_r.
  int         key_r = 0;
  logic [3:0] key_mask = 4'h0;
  logic [3:0] row_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.ROW_DWELL(16'd4), .DEB_CYCLES(8'd3)) dut (
    .clk(clk), .rst(rst), .col_n(col_n),
    .row_n(row_n), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge, reflecting the matrix seen by the current row.
  task automatic step();
    @(negedge clk);
    #1;
    col_n = (row_n[key_r] == 1'b0) ? ~key_mask : 4'hF;
  endtask

  // Reference model: keypad behaviour stated as rules over synchronized column samples.
  int         m_mode = M_SCAN, m_row = 0, m_col = 0, m_dwell = 0, m_deb = 0;
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_code = 4'h0;
  logic       m_valid = 1'b0, m_held = 1'b0;

  always @(posedge clk) begin
    logic [3:0] s;
    s = m_s2;
    m_valid = 1'b0;
    if (rst) begin
      m_mode = M_SCAN; m_row = 0; m_col = 0; m_dwell = 0; m_deb = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0;
    end else begin
      m_s2 = m_s1;
      m_s1 = col_n;
      case (m_mode)
        M_SCAN:
          if (m_dwell < RD - 1) m_dwell++;
          else if (s == 4'hF) begin m_row = (m_row + 1) % 4; m_dwell = 0; end
          else begin
            for (int c = 3; c >= 0; c--) if (!s[c]) m_col = c;
            m_mode = M_PRESS; m_deb = 0;
          end
        M_PRESS:
          if (s[m_col]) begin m_mode = M_SCAN; m_dwell = 0; end
          else if (m_deb == DC - 1) begin
            m_mode = M_HELD; m_valid = 1'b1; m_code = 4'(4 * m_row + m_col);
          end else m_deb++;
        M_HELD:
          if (s[m_col]) begin m_mode = M_REL; m_deb = 0; end
        default:
          if (!s[m_col]) m_mode = M_HELD;
          else if (m_deb == DC - 1) begin m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_dwell = 0; end
          else m_deb++;
      endcase
    end
    m_held = (m_mode == M_HELD || m_mode == M_REL);
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) valid_seen++;
    if (cmp_on) begin
      check("cyc_row_n", row_n, row_pat[m_row]);
      check("cyc_key_code", key_code, m_code);
      check("cyc_key_valid", key_valid, m_valid);
      check("cyc_key_held", key_held, m_held);
    end
  end

  task automatic wait_valid(string name, int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (key_valid === 1'b1) got = 1'b1;
    end
    check(name, got, 1);
  endtask

  task automatic wait_row_start(string name, logic [3:0] target, logic [3:0] prev_pat);
    bit got;
    logic [3:0] prev;
    got = 1'b0;
    prev = row_n;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (row_n == target && prev == prev_pat) got = 1'b1;
      prev = row_n;
    end
    check(name, got, 1);
  endtask

  initial begin
    int v0;
    rst = 1'b1;
    step();
    cmp_on = 1'b1;
    step();
    step();
    check("rst_row_n", row_n, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);

    // Idle scan: each row visible for 4 samples, first row includes the reset cycle.
    rst = 1'b0;
    v0 = valid_seen;
    for (int k = 0; k < 32; k++) begin
      step();
      check("idle_row_n", row_n, row_pat[((k + 1) / 4) % 4]);
    end
    check("idle_no_valid", valid_seen - v0, 0);

    // Clean press of row 2 column 2.
    key_r = 2; key_mask = 4'b0100;
    v0 = valid_seen;
    wait_valid("press_timeout", 80);
    check("press_code", key_code, 4'hA);
    check("press_held", key_held, 1'b1);
    repeat (8) step();
    check("press_one_valid", valid_seen - v0, 1);
    check("press_row_frozen", row_n, 4'b1011);
    key_mask = 4'h0;
    step();
    repeat (5) step();
    check("release_held_still", key_held, 1'b1);
    step();
    check("release_held_drop", key_held, 1'b0);
    check("release_next_row", row_n, 4'b0111);

    // Release bounce: high 2, low 1, then high.
    key_mask = 4'b0100;
    v0 = valid_seen;
    wait_valid("rb_press_timeout", 80);
    key_mask = 4'h0;
    step(); check("rb_held_a0", key_held, 1'b1);
    step(); check("rb_held_a1", key_held, 1'b1);
    key_mask = 4'b0100;
    step(); check("rb_held_a2", key_held, 1'b1);
    key_mask = 4'h0;
    for (int i = 3; i <= 8; i++) begin
      step();
      check("rb_held_mid", key_held, 1'b1);
    end
    step();
    check("rb_held_drop", key_held, 1'b0);
    check("rb_one_valid", valid_seen - v0, 1);
    check("rb_next_row", row_n, 4'b0111);

    // Press bounce on row 1: column low for two debounce cycles, then high.
    v0 = valid_seen;
    wait_row_start("bounce_row_timeout", 4'b1101, 4'b1110);
    key_r = 1; key_mask = 4'b0001;
    repeat (3) step();
    key_mask = 4'h0;
    step();
    repeat (6) step();
    check("bounce_same_row", row_n, 4'b1101);
    step();
    check("bounce_fresh_dwell", row_n, 4'b1011);
    check("bounce_no_valid", valid_seen - v0, 0);

    // Priority: columns 1 and 3 low on row 1, column 1 wins.
    key_r = 1; key_mask = 4'b1010;
    v0 = valid_seen;
    wait_valid("prio_timeout", 80);
    check("prio_code", key_code, 4'h5);
    key_mask = 4'h0;
    begin
      bit dropped;
      dropped = 1'b0;
      for (int i = 0; i < 30 && !dropped; i++) begin
        step();
        if (key_held === 1'b0) dropped = 1'b1;
      end
      check("prio_release_timeout", dropped, 1);
    end
    check("prio_one_valid", valid_seen - v0, 1);

    // Reset one cycle before the press would be accepted.
    wait_row_start("rstmid_row_timeout", 4'b1110, 4'b0111);
    key_r = 0; key_mask = 4'b1000;
    v0 = valid_seen;
    repeat (5) step();
    rst = 1'b1;
    step();
    check("rstmid_valid", key_valid, 1'b0);
    check("rstmid_row_n", row_n, 4'b1110);
    check("rstmid_code", key_code, 4'h0);
    check("rstmid_held", key_held, 1'b0);
    rst = 1'b0; key_mask = 4'h0;
    step();
    check("rstmid_restart_row", row_n, 4'b1110);
    repeat (12) step();
    check("rstmid_no_valid", valid_seen - v0, 0);
    check("rstmid_code_kept", key_code, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
